// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder assembled from 1-bit full-adder cells.
// Registers the sum, the MSB carry-out and the carry into the MSB.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic p;

    assign p    = x ^ y;
    assign sum  = p ^ cin;
    assign cout = (x & y) | (cin & p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             last_ci,
    output logic             out_valid
);
    logic [WIDTH-1:0] sum;
    logic             carry_msb;
    logic             carry_into_msb;

    // Each cell owns its carry-out net; the next cell picks it up by
    // reference, so the chain is a strict ripple with no shared vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic cin;
        logic cout;
        logic sbit;

        if (i == 0) begin : g_first
            assign cin = ci;
        end else begin : g_rest
            assign cin = g_fa[i-1].cout;
        end

        full_adder u_fa (
            .x    (a[i]),
            .y    (b[i]),
            .cin  (cin),
            .sum  (sbit),
            .cout (cout)
        );

        assign sum[i] = sbit;
    end

    assign carry_msb      = g_fa[WIDTH-1].cout;
    assign carry_into_msb = g_fa[WIDTH-1].cin;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s         <= '0;
            co        <= 1'b0;
            last_ci   <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            s         <= sum;
            co        <= carry_msb;
            last_ci   <= carry_into_msb;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder: expected results are queued at
// drive time and checked one cycle later against a WIDTH+1-bit reference.

module tb_ripple_carry_adder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         lc;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         last_ci;
    logic         out_valid;

    exp_t         q[$];
    int           checks = 0;
    int           passed = 0;
    logic [W-1:0] hs = '0;
    logic         hco = 1'b0;
    logic         hlc = 1'b0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .s         (s),
        .co        (co),
        .last_ci   (last_ci),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vci, input logic vv, input logic vr);
        logic [W:0]   full;
        logic [W-1:0] low;
        exp_t         e;
        e = '0;
        a = va; b = vb; ci = vci; in_valid = vv; rst = vr;
        full = {1'b0, va} + {1'b0, vb} + (W+1)'(vci);
        low  = {1'b0, va[W-2:0]} + {1'b0, vb[W-2:0]} + W'(vci);
        if (vv && vr)
            q.push_back('{full[W-1:0], full[W], low[W-1],
                          (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1])});
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, vv && vr);
        if (!vr) begin
            hs = '0; hco = 1'b0; hlc = 1'b0;
        end else if (vv) begin
            if (q.size() == 0) begin
                checks++;
                $error("FAIL scoreboard_empty observed=0 expected=1");
            end else begin
                e = q.pop_front();
                hs = e.s; hco = e.co; hlc = e.lc;
            end
        end
        chk("s", s, hs);
        chk("co", co, hco);
        chk("last_ci", last_ci, hlc);
        if (vv && vr)
            chk("overflow", last_ci ^ co, e.ovf);
    endtask

    initial begin
        // Reset held with valid operands present: everything stays zero.
        step(32'h1234, 32'h1, 1'b0, 1'b1, 1'b0);
        step(32'h1234, 32'h1, 1'b0, 1'b1, 1'b0);
        chk("reset_s", s, 0);

        step(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
        chk("simple_s", s, 12);
        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("hold_s", s, 12);

        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        chk("wrap_co_lc", {co, last_ci}, 2'b11);
        step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        chk("ovf_pos_s", s, 32'h8000_0000);
        step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        chk("ovf_neg_co_lc", {co, last_ci}, 2'b10);
        step(32'd10, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
        chk("sub_s", s, 7);
        step(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("ci_wrap_co", co, 1);
        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++)
            step($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, i != 500);

        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
